// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter: mode encodings.
package counter_pkg;
    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;
endpackage

// File: rtl/counter_mod_next.sv
// Combinational next-state and terminal-count logic for counter_mod.
// COUNTER_SAT_EN makes up/down modes saturate instead of wrapping.
module counter_mod_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             cur_dir,
    input  logic [1:0]       mode,
    input  logic             en,
    output logic [WIDTH-1:0] nxt,
    output logic             nxt_dir,
    output logic             tc
);
    localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_N = MAX_W[WIDTH-1:0];
`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [WIDTH:0] cur_w;
    logic           at_max;
    logic           at_zero;

    assign cur_w   = {1'b0, cur};
    assign at_max  = (cur_w >= MAX_W);
    assign at_zero = (cur_w == '0);

    always_comb begin
        nxt     = cur;
        nxt_dir = cur_dir;
        tc      = 1'b0;
        if (en) begin
            unique case (mode)
                MODE_UP: begin
                    nxt_dir = 1'b1;
                    tc      = at_max;
                    if (at_max) nxt = SAT ? MAX_N : '0;
                    else        nxt = WIDTH'(cur_w + ONE_W);
                end
                MODE_DOWN: begin
                    nxt_dir = 1'b0;
                    tc      = at_zero;
                    if (at_zero) nxt = SAT ? '0 : MAX_N;
                    else         nxt = WIDTH'(cur_w - ONE_W);
                end
                MODE_PINGPONG: begin
                    if (cur_dir) begin
                        tc = at_max;
                        // Bounce off the top: step back down and reverse.
                        if (at_max) begin
                            nxt     = WIDTH'(MAX_W - ONE_W);
                            nxt_dir = 1'b0;
                        end else begin
                            nxt = WIDTH'(cur_w + ONE_W);
                        end
                    end else begin
                        tc = at_zero;
                        if (at_zero) begin
                            nxt     = WIDTH'(ONE_W);
                            nxt_dir = 1'b1;
                        end else begin
                            nxt = WIDTH'(cur_w - ONE_W);
                        end
                    end
                end
                default: begin
                    nxt     = cur;
                    nxt_dir = cur_dir;
                    tc      = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/counter_mod.sv
// Parametrised modulo counter with up/down/ping-pong/hold modes, clear, load and tc.
// Define COUNTER_SAT_EN for saturating up/down modes.
module counter_mod
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             dir,
    output logic             tc
);
    localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_N = MAX_W[WIDTH-1:0];

    logic [WIDTH-1:0] out_q, out_d, cnt_next, load_clamped;
    logic             dir_q, dir_d, dir_next;

    counter_mod_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .cur     (out_q),
        .cur_dir (dir_q),
        .mode    (mode),
        .en      (en),
        .nxt     (cnt_next),
        .nxt_dir (dir_next),
        .tc      (tc)
    );

    assign load_clamped = ({1'b0, load_val} > MAX_W) ? MAX_N : load_val;

    always_comb begin
        out_d = cnt_next;
        dir_d = dir_next;
        if (clr) begin
            out_d = '0;
            dir_d = 1'b1;
        end else if (load) begin
            out_d = load_clamped;
            dir_d = dir_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            dir_q <= 1'b1;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
        end
    end

    assign out = out_q;
    assign dir = dir_q;
endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench for counter_mod (WIDTH=4, MODULUS=10) against a behavioural model.
module tb_counter_mod;
    localparam int M = 10;
`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, clr, load;
    logic [1:0] mode;
    logic [3:0] load_val;
    logic [3:0] out;
    logic       dir, tc;

    int tests = 0;
    int fails = 0;

    counter_mod #(
        .WIDTH   (4),
        .MODULUS (M)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .dir      (dir),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    // Behavioural model: count kept as a plain integer.
    int m_cnt;
    bit m_dir;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt <= 0;
            m_dir <= 1'b1;
        end else if (clr) begin
            m_cnt <= 0;
            m_dir <= 1'b1;
        end else if (load) begin
            m_cnt <= (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
        end else if (en) begin
            case (mode)
                2'd0: begin
                    m_cnt <= SAT ? ((m_cnt + 1 > M - 1) ? M - 1 : m_cnt + 1) : (m_cnt + 1) % M;
                    m_dir <= 1'b1;
                end
                2'd1: begin
                    m_cnt <= SAT ? ((m_cnt == 0) ? 0 : m_cnt - 1) : (m_cnt + M - 1) % M;
                    m_dir <= 1'b0;
                end
                2'd2: begin
                    if (m_dir && m_cnt == M - 1)      begin m_cnt <= M - 2; m_dir <= 1'b0; end
                    else if (!m_dir && m_cnt == 0)    begin m_cnt <= 1;     m_dir <= 1'b1; end
                    else if (m_dir)                   m_cnt <= m_cnt + 1;
                    else                              m_cnt <= m_cnt - 1;
                end
                default: ;
            endcase
        end
    end

    function automatic bit model_tc();
        if (!en || mode == 2'd3) return 1'b0;
        if (mode == 2'd0) return m_cnt == M - 1;
        if (mode == 2'd1) return m_cnt == 0;
        return m_dir ? (m_cnt == M - 1) : (m_cnt == 0);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("model_out", int'(out), m_cnt);
        check("model_dir", int'(dir), int'(m_dir));
        check("model_tc", int'(tc), int'(model_tc()));
    end

    // Advance one edge; return just after the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    int exp_v;

    initial begin
        rst = 1'b0; en = 1'b0; mode = 2'd0; clr = 1'b0; load = 1'b0; load_val = '0;
        repeat (3) tick();
        check("reset_out", int'(out), 0);
        check("reset_dir", int'(dir), 1);
        rst = 1'b1;

        // Up count: 0..9,0,1 with tc exactly at 9.
        mode = 2'd0; en = 1'b1;
        check("up_tc_at0", int'(tc), 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_v = i % 10;
            check("up_out", int'(out), exp_v);
            check("up_tc", int'(tc), (exp_v == 9) ? 1 : 0);
        end

        // Down from 2.
        en = 1'b0; load = 1'b1; load_val = 4'd2;
        tick();
        load = 1'b0; mode = 2'd1; en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (SAT) exp_v = (i == 1) ? 1 : 0;
            else     exp_v = (i == 1) ? 1 : (i == 2) ? 0 : (i == 3) ? 9 : 8;
            check("down_out", int'(out), exp_v);
            check("down_tc", int'(tc), (exp_v == 0) ? 1 : 0);
        end

        // Ping-pong from cleared state, 20 edges.
        en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; mode = 2'd2; en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_v = (k <= 9) ? k : (k <= 18) ? 18 - k : k - 18;
            check("pp_out", int'(out), exp_v);
            check("pp_dir", int'(dir), (k <= 9 || k >= 19) ? 1 : 0);
        end

        // Load clamps and keeps dir; clr beats load.
        mode = 2'd1; en = 1'b1;
        tick();
        en = 1'b0; load = 1'b1; load_val = 4'd13;
        tick();
        check("load_clamp_out", int'(out), 9);
        check("load_dir_kept", int'(dir), 0);
        clr = 1'b1; load_val = 4'd5;
        tick();
        check("clr_load_out", int'(out), 0);
        check("clr_load_dir", int'(dir), 1);
        clr = 1'b0; load = 1'b0;

        // Enable/hold gating.
        load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0; mode = 2'd0; en = 1'b0;
        #1 check("tc_en0", int'(tc), 0);
        tick();
        check("en0_hold_out", int'(out), 9);
        mode = 2'd3; en = 1'b1;
        #1 check("tc_hold", int'(tc), 0);
        tick();
        check("hold_out", int'(out), 9);
        mode = 2'd0;
        #1 check("tc_up9", int'(tc), 1);
        tick();
        check("resume_out", int'(out), SAT ? 9 : 0);

        // Asynchronous reset between edges at out=7.
        en = 1'b0; load = 1'b1; load_val = 4'd7; mode = 2'd1;
        tick();
        load = 1'b0;
        en = 1'b1;
        check("pre_rst_out", int'(out), 7);
        #1 rst = 1'b0;
        #1;
        check("async_rst_out", int'(out), 0);
        check("async_rst_dir", int'(dir), 1);
        tick();
        rst = 1'b1; mode = 2'd0;
        tick();
        check("post_rst_out", int'(out), 1);

        // Randomized phase checked by the compare process.
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(9) < 7);
            mode     = 2'($urandom_range(3));
            clr      = ($urandom_range(19) == 0);
            load     = ($urandom_range(9) == 0);
            load_val = 4'($urandom_range(15));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
